// File: rtl/img_pkg.sv
// Shared image-pipeline types: pixel and 3x3 window containers plus the window-generator FSM states.
package img_pkg;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int PIX_W          = 8;

  typedef logic [PIX_W-1:0] pixel_t;
  // Element 8 is top-left (oldest line, oldest column); element 0 is the newest pixel.
  typedef pixel_t [8:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ACTIVE
  } win_state_t;
endpackage

// File: rtl/line_fifo.sv
// One-line delay: circular RAM whose output is the entry written DEPTH shifts ago.
// Read happens before write, so dout during a shift is the old entry.
module line_fifo #(
  parameter int DEPTH = 640,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_ptr;

  assign dout = r_mem[r_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (shift_en) begin
      r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + AW'(1);
    end
  end

  // Contents are never exposed before being overwritten, so no reset is needed.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      r_mem[r_ptr] <= din;
    end
  end
endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream in, one registered 3x3 neighbourhood per interior pixel out, 1 clock after accept.
// No backpressure: the stream advances only on pixel_valid, and gaps simply hold all state.
module sobel_window_gen
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int PIX_W      = img_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pixel_data,
  input  logic               pixel_valid,
  input  logic               frame_start,
  output logic [9*PIX_W-1:0] window,
  output logic               window_valid,
  output logic               frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  win_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [8:0][PIX_W-1:0] r_win;
  logic [PIX_W-1:0] w_tap0, w_tap1;
  logic w_accept, w_col_last, w_last_pix;

  assign w_accept   = pixel_valid & ((r_state != IDLE) | frame_start);
  // frame_start always rebases the pixel to (0,0), even mid-frame.
  assign w_col      = frame_start ? '0 : r_col;
  assign w_row      = frame_start ? '0 : r_row;
  assign w_col_last = (w_col == COL_LAST);
  assign w_last_pix = w_col_last & (w_row == ROW_LAST);

  line_fifo #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_fifo0 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_accept),
    .din      (pixel_data),
    .dout     (w_tap1)
  );

  line_fifo #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_fifo1 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_accept),
    .din      (w_tap1),
    .dout     (w_tap0)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (w_last_pix) begin
        w_state_nxt = IDLE;
      end else if (w_col_last && (w_row == RW'(1))) begin
        w_state_nxt = ACTIVE;
      end else if (frame_start) begin
        w_state_nxt = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // Col 0/1 windows straddle the previous line, so only col >= 2 is reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win        <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
      frame_done   <= w_accept && w_last_pix;
      if (w_accept) begin
        r_win <= {r_win[7:6], w_tap0, r_win[4:3], w_tap1, r_win[1:0], pixel_data};
      end
    end
  end

  assign window = r_win;
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Upstream feeder of the Sobel edge stage.
- Accepts a raster-order 8-bit grayscale pixel stream, buffers the two previous image lines, and emits one 3x3 neighbourhood per interior pixel.
- Output window is registered; the Sobel stage consumes it directly. There is no backpressure.

Parameters:
- IMG_WIDTH, 640, pixels per line; minimum 3.
- IMG_HEIGHT, 480, lines per frame; minimum 3.
- PIX_W, 8, bits per pixel.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pixel_data  input  PIX_W  incoming pixel.
- pixel_valid  input  1  pixel_data is accepted this cycle.
- frame_start  input  1  qualified by pixel_valid; marks the pixel at (row 0, col 0).
- window  output  9*PIX_W  3x3 neighbourhood, row-major. [71:64] is top-left (oldest line, oldest column); [7:0] is bottom-right (newest pixel).
- window_valid  output  1  window holds a valid interior neighbourhood; one-cycle pulse per window.
- frame_done  output  1  one-cycle pulse, registered with the last pixel's window.

Behaviour:
- Reset (async):
  - window = 0, window_valid = 0, frame_done = 0.
  - Row and column counters = 0; FSM = IDLE.
  - Line buffer contents are don't-care; they are never exposed before being overwritten.
- FSM states and transitions:
  - IDLE -> FILL on pixel_valid & frame_start. That pixel is taken as (0,0).
  - FILL covers rows 0-1. FILL -> ACTIVE when the pixel at (1, IMG_WIDTH-1) is accepted.
  - ACTIVE covers rows 2..IMG_HEIGHT-1. ACTIVE -> IDLE after accepting (IMG_HEIGHT-1, IMG_WIDTH-1); frame_done pulses in the next cycle.
  - In IDLE, pixels without frame_start are dropped with no state change.
- Acceptance: a pixel is accepted only when pixel_valid = 1 and the FSM is not in IDLE (or the pixel carries frame_start). When pixel_valid = 0, everything holds; arbitrary gaps are allowed.
- Counters:
  - col increments per accepted pixel and wraps IMG_WIDTH-1 -> 0; row increments on that wrap.
  - Widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).
- Line buffers:
  - Two cascaded FIFOs, each IMG_WIDTH deep, shifting only on acceptance.
  - Taps per accepted pixel:
    - tap2 = pixel_data (current row r).
    - tap1 = output of FIFO0 (row r-1).
    - tap0 = output of FIFO1 (row r-2).
  - FIFO0 is written with pixel_data; FIFO1 is written with the FIFO0 output.
  - Read-before-write within a cycle: the read returns the old entry.
- Window registers:
  - Three 3-deep column shift registers (top/mid/bottom), loaded with tap0/tap1/tap2 on acceptance.
  - window reflects them after the edge.
- window_valid:
  - Set in the cycle after acceptance of a pixel with row >= 2 and col >= 2.
  - Otherwise 0, including the col 0 and col 1 pixels of each row, which cover the wrap from the previous line.
  - Latency is 1 clock from accept to window_valid.
  - Window centre = (row-1, col-1).
  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
  - Border pixels get no window; the downstream stage zero-fills borders.
- frame_start while not in IDLE: abort the current frame.
  - The pixel becomes (0,0) of the new frame; FSM -> FILL.
  - No frame_done for the aborted frame; window_valid = 0 in the following cycle.
- frame_start at exactly (0,0) timing, i.e. back-to-back with the previous frame's last pixel, is legal. The new frame starts with no gap cycle.
- Asserting rst mid-frame clears everything immediately; the stream must restart with frame_start.
- Arithmetic: there is none beyond the counters; pixel values pass through unmodified.

Decomposition:
- Shared package `img_pkg`:
  - Constants IMG_WIDTH_DEF and IMG_HEIGHT_DEF, PIX_W.
  - Typedef pixel_t.
  - Typedef window_t (9 x pixel_t), which the Sobel stage reuses.
  - Enum win_state_t {IDLE, FILL, ACTIVE}.
- One sub-module, `line_fifo`:
  - Parameters DEPTH and W; inputs shift_en and din; output dout (oldest entry).
  - Circular RAM with a wrapping pointer, instantiated twice.

Test Plan:
- W=4, H=4, pixel = row*16+col, continuous valid with frame_start on (0,0).
  - Expected: 4 window_valid pulses.
  - First pulse one clock after (2,2), window = {00,01,02,10,11,12,20,21,22}.
  - Last window = {11,12,13,21,22,23,31,32,33}.
  - frame_done pulses together with the last window.
- Same frame with pixel_valid toggling 1-0-0-1 randomly.
  - Expected: identical window sequence; window_valid never asserted during a gap.
- Row wrap check.
  - Expected: after (2,3), pixels (3,0) and (3,1) produce window_valid = 0.
  - The next pulse follows (3,2) with window = {10,11,12,20,21,22,30,31,32}.
- frame_start reasserted at (2,1) with new data 0x80+row*16+col.
  - Expected: no frame_done for the aborted frame.
  - First new window follows new (2,2) = {80,81,82,90,91,92,A0,A1,A2}.
- rst pulsed mid-row 2; then pixels without frame_start; then a full frame.
  - Expected: outputs 0 immediately on rst; stray pixels ignored.
  - The full frame then behaves exactly as in the first scenario.
- Two back-to-back frames, no gap, W=5, H=3.
  - Expected: 3 windows per frame and 2 frame_done pulses.
  - The second frame's windows contain no first-frame data.
